// File: rtl/mem_arb.sv
// mem_arb: two-master write arbiter that puts CPU (m0) and a second writer (m1)
// on one registered addr/data/we memory write bus. It uses round-robin with a
// bounded burst. Define MEM_ARB_FIXED_PRIO_EN to give master 0 fixed priority.
// Ports: clk, rst (sync, active-high); mX_req/mX_addr/mX_data in, mX_gnt out;
//        mem_addr/mem_data/mem_we out (registered, one we pulse per transfer).

module mem_arb #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data,
  output logic              m0_gnt,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data,
  output logic              m1_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  state_t          state;
  logic            last;
  logic [CW-1:0]   cnt;
  logic            burst_end;

  // Grants come straight from the state register: no req->gnt path.
  assign m0_gnt    = (state == OWN0);
  assign m1_gnt    = (state == OWN1);
  assign burst_end = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      cnt      <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_we   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (m0_req && m1_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            state <= OWN0;
`else
            // Tie goes to whoever did not own the bus last.
            state <= last ? OWN0 : OWN1;
`endif
          end else if (m0_req) begin
            state <= OWN0;
          end else if (m1_req) begin
            state <= OWN1;
          end
        end

        OWN0: begin
          if (m0_req) begin
            mem_we   <= 1'b1;
            mem_addr <= m0_addr;
            mem_data <= m0_data;
            if (burst_end) begin
              cnt <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
              // Burst limit hit with m1 waiting: zero-bubble handover.
              if (m1_req) begin
                state <= OWN1;
                last  <= 1'b0;
              end
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt   <= '0;
            last  <= 1'b0;
            state <= m1_req ? OWN1 : IDLE;
          end
        end

        OWN1: begin
          if (m1_req) begin
            mem_we   <= 1'b1;
            mem_addr <= m1_addr;
            mem_data <= m1_data;
`ifdef MEM_ARB_FIXED_PRIO_EN
            // m0 preempts as soon as it asks, whatever the count.
            if (m0_req) begin
              state <= OWN0;
              cnt   <= '0;
              last  <= 1'b1;
            end else if (burst_end) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
`else
            if (burst_end) begin
              cnt <= '0;
              if (m0_req) begin
                state <= OWN0;
                last  <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
`endif
          end else begin
            cnt   <= '0;
            last  <= 1'b1;
            state <= m0_req ? OWN0 : IDLE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-master write arbiter in front of the CPU memory-mapped write port (the `addr`/`data`/`we` bus feeding the memory controller and its output-capture register at 0x20). It lets the CPU data port (master 0) and a second writer (master 1, e.g. a debug/loader unit) share that single write bus. Arbitration is round-robin with a bounded burst length, and every write is issued as a registered single-cycle pulse.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MAX_BURST`, 4, max consecutive writes per tenure while the other master waits; must be >= 1.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `m0_req`  in  1  master 0 write request; hold with addr/data stable until transferred.
- `m0_addr`  in  ADDR_W  master 0 write address.
- `m0_data`  in  DATA_W  master 0 write data.
- `m0_gnt`  out  1  master 0 owns bus; a transfer occurs on any edge with `m0_req & m0_gnt`.
- `m1_req`, `m1_addr`, `m1_data`, `m1_gnt`: same as master 0.
- `mem_addr`  out  ADDR_W  registered write address to memory controller.
- `mem_data`  out  DATA_W  registered write data.
- `mem_we`  out  1  registered write strobe; one cycle per transfer.

## Operation
- States: IDLE, OWN0, OWN1. `mX_gnt` is decoded from the state register only; there is no combinational path from req to gnt.
- Registers: `last` (last owner), `cnt` (transfers in current tenure, width `$clog2(MAX_BURST+1)`).
- IDLE, neither requesting: stay.
- IDLE, one requesting: go to that OWN state.
- IDLE, both requesting: go to OWN of the master != `last`.
- No transfer happens in IDLE.
- OWNx, edge with `mx_req=1` (transfer):
  - Register `mem_addr`/`mem_data` from mx and set `mem_we=1`.
  - `cnt+1`; if `cnt==MAX_BURST-1` and the other master is requesting: go to OWN(other), `cnt=0`, `last=x`.
  - If `cnt==MAX_BURST-1` and the other is idle: `cnt=0`, stay in OWNx.
- OWNx, edge with `mx_req=0`: if the other is requesting, go to OWN(other), else go to IDLE; `cnt=0`, `last=x`.
- Edges without a transfer: `mem_we=0`; `mem_addr`/`mem_data` hold their last values.
- `MAX_BURST=1`: strict alternation while both request.

## Timing
- Reset values: state IDLE, `last=1` (master 0 wins the first tie), `cnt=0`, `mem_addr=0`, `mem_data=0`, `mem_we=0`, `m0_gnt=m1_gnt=0`.
- Arbitration latency from IDLE: req rises in cycle c, `gnt` high in c+1, transfer at end of c+1, `mem_we` high in c+2.
- Throughput: 1 write/cycle while the owner holds req.
- Handover on burst limit is zero-bubble. The last transfer of A and the switch happen on the same edge; B's gnt is high the next cycle.
- Handover on owner drop costs one cycle with no gnt to B. The edge that sees `req=0` switches; B transfers one cycle later.
- Simultaneous req rise in IDLE: resolved by `last` as above.
- `rst` mid-burst: the in-flight transfer for that edge is discarded. The next cycle shows all reset values, including `mem_we=0`.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined: fixed priority for master 0.
  - IDLE tie goes to master 0.
  - OWN1 yields to OWN0 on any edge where `m0_req=1`. This applies after a transfer too, regardless of `cnt`.
  - OWN0 ignores the `MAX_BURST` limit.
- Undefined: round-robin/burst behaviour as described in Operation.

## Test plan
- Reset: assert `rst` 2 cycles while both reqs are high. All outputs read 0, and the first grant after release goes to master 0.
- Single write: `m0_req` with addr 0x20, data 0x0000_1234 in cycle 0. Expect `m0_gnt=1` in cycle 1, then `mem_we=1`, `mem_addr=0x20`, `mem_data=0x1234` in cycle 2, then `mem_we=0` in cycle 3.
- Contention, `MAX_BURST=4`, both reqs held with incrementing data:
  - `mem_we` high every cycle, no bubbles.
  - Writes come in groups of 4 from m0, then 4 from m1, alternating.
- Late requester: m1 bursts 10 writes and m0 requests after m1's 2nd transfer. m1 completes writes 3 and 4, then `m0_gnt` is high in the next cycle.
- Drop and reset:
  - m0 drops req mid-tenure while m1 waits: one cycle with no gnt, then `m1_gnt=1`.
  - `rst` during an m1 burst: `mem_we=0` and IDLE the following cycle.
- `MEM_ARB_FIXED_PRIO_EN`: m1 owning and m0 asserting req: m1's current transfer completes, `m0_gnt=1` the next cycle, and m0 keeps the bus for 8 or more writes.
